// File: rtl/stopwatch_lap_timer.sv
// stopwatch_lap_timer
//   Minutes:seconds stopwatch with a built-in one-second prescaler, count-up
//   with configurable minute range, count-down with preload and expiry, and a
//   lap-capture register. Sits between the debounced control logic and the
//   display driver.
//
// Parameters
//   TICKS_PER_SEC  clock cycles per one-second tick (>= 1)
//   MIN_WIDTH      width of the minutes field
//   MAX_MIN        highest minute value before count-up wraps to 0:00
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   start, stop, clear, lap  control pulses (priority clear > load_en > stop > start)
//   mode_down                count direction, sampled on start from IDLE
//   load_en/load_min/sec     preset time, honoured in IDLE or PAUSED
//   minutes, seconds         current time
//   lap_minutes/seconds      captured time, lap_valid pulses the cycle after
//   wrap, expired            one-cycle event pulses
//   status                   00 IDLE, 01 RUNNING, 10 PAUSED, 11 EXPIRED
module stopwatch_lap_timer #(
  parameter int TICKS_PER_SEC = 4,
  parameter int MIN_WIDTH     = 8,
  parameter int MAX_MIN       = 99
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 clear,
  input  logic                 lap,
  input  logic                 mode_down,
  input  logic                 load_en,
  input  logic [MIN_WIDTH-1:0] load_min,
  input  logic [5:0]           load_sec,
  output logic [MIN_WIDTH-1:0] minutes,
  output logic [5:0]           seconds,
  output logic [MIN_WIDTH-1:0] lap_minutes,
  output logic [5:0]           lap_seconds,
  output logic                 lap_valid,
  output logic                 wrap,
  output logic                 expired,
  output logic [1:0]           status
);

  localparam int PS_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PS_W-1:0]      PS_LAST  = PS_W'(TICKS_PER_SEC - 1);
  localparam logic [MIN_WIDTH-1:0] MIN_LAST = MIN_WIDTH'(MAX_MIN);
  localparam logic [5:0]           SEC_LAST = 6'd59;

  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_RUNNING = 2'b01;
  localparam logic [1:0] ST_PAUSED  = 2'b10;
  localparam logic [1:0] ST_EXPIRED = 2'b11;

  // Preset values are saturated so the time register never holds an
  // out-of-range value.
  function automatic logic [MIN_WIDTH-1:0] sat_min(input logic [MIN_WIDTH-1:0] m);
    return (m > MIN_LAST) ? MIN_LAST : m;
  endfunction

  function automatic logic [5:0] sat_sec(input logic [5:0] s);
    return (s > SEC_LAST) ? SEC_LAST : s;
  endfunction

  logic [1:0]           state_q, state_d;
  logic [PS_W-1:0]      presc_q, presc_d;
  logic                 mode_q, mode_d;
  logic [MIN_WIDTH-1:0] min_q, min_d;
  logic [5:0]           sec_q, sec_d;
  logic [MIN_WIDTH-1:0] lap_min_q, lap_min_d;
  logic [5:0]           lap_sec_q, lap_sec_d;
  logic                 lap_vld_q, lap_vld_d;
  logic                 wrap_q, wrap_d;
  logic                 expired_q, expired_d;

  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    mode_d    = mode_q;
    min_d     = min_q;
    sec_d     = sec_q;
    lap_min_d = lap_min_q;
    lap_sec_d = lap_sec_q;
    lap_vld_d = 1'b0;
    wrap_d    = 1'b0;
    expired_d = 1'b0;

    if (clear) begin
      state_d   = ST_IDLE;
      presc_d   = '0;
      min_d     = '0;
      sec_d     = '0;
      lap_min_d = '0;
      lap_sec_d = '0;
    end else begin
      // Lap captures the value visible this cycle, before any tick update.
      if (state_q == ST_RUNNING && lap) begin
        lap_min_d = min_q;
        lap_sec_d = sec_q;
        lap_vld_d = 1'b1;
      end

      case (state_q)
        ST_IDLE: begin
          if (load_en) begin
            min_d = sat_min(load_min);
            sec_d = sat_sec(load_sec);
          end else if (start && !stop &&
                       !(mode_down && min_q == '0 && sec_q == '0)) begin
            state_d = ST_RUNNING;
            mode_d  = mode_down;
            presc_d = '0;
          end
        end

        ST_PAUSED: begin
          if (load_en) begin
            min_d = sat_min(load_min);
            sec_d = sat_sec(load_sec);
          end else if (start && !stop) begin
            // Prescaler resumes from its held phase.
            state_d = ST_RUNNING;
          end
        end

        ST_RUNNING: begin
          // A stop freezes both prescaler and time on this edge.
          if (stop) begin
            state_d = ST_PAUSED;
          end else if (presc_q != PS_LAST) begin
            presc_d = presc_q + 1'b1;
          end else begin
            presc_d = '0;
            if (mode_q) begin
              // 0:01 (or an already-zero time resumed in down mode) expires.
              if (min_q == '0 && sec_q <= 6'd1) begin
                min_d     = '0;
                sec_d     = '0;
                state_d   = ST_EXPIRED;
                expired_d = 1'b1;
              end else if (sec_q == '0) begin
                sec_d = SEC_LAST;
                min_d = min_q - 1'b1;
              end else begin
                sec_d = sec_q - 6'd1;
              end
            end else begin
              if (sec_q == SEC_LAST) begin
                sec_d = '0;
                if (min_q == MIN_LAST) begin
                  min_d  = '0;
                  wrap_d = 1'b1;
                end else begin
                  min_d = min_q + 1'b1;
                end
              end else begin
                sec_d = sec_q + 6'd1;
              end
            end
          end
        end

        default: ; // EXPIRED: only clear or rst leaves
      endcase
    end
  end

  // ---- register stage ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      presc_q   <= '0;
      mode_q    <= 1'b0;
      min_q     <= '0;
      sec_q     <= '0;
      lap_min_q <= '0;
      lap_sec_q <= '0;
      lap_vld_q <= 1'b0;
      wrap_q    <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      mode_q    <= mode_d;
      min_q     <= min_d;
      sec_q     <= sec_d;
      lap_min_q <= lap_min_d;
      lap_sec_q <= lap_sec_d;
      lap_vld_q <= lap_vld_d;
      wrap_q    <= wrap_d;
      expired_q <= expired_d;
    end
  end

  assign minutes     = min_q;
  assign seconds     = sec_q;
  assign lap_minutes = lap_min_q;
  assign lap_seconds = lap_sec_q;
  assign lap_valid   = lap_vld_q;
  assign wrap        = wrap_q;
  assign expired     = expired_q;
  assign status      = state_q;

endmodule

// File: tb/tb_stopwatch_lap_timer.sv
// Testbench for stopwatch_lap_timer: directed vector table, hand-written
// count-up / async-reset sequence, and randomized run against a model that
// keeps time as a single total-seconds integer.
module tb_stopwatch_lap_timer;

  localparam int TPS  = 4;
  localparam int MW   = 8;
  localparam int MAXM = 99;
  localparam int SPAN = (MAXM + 1) * 60;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, stop, clear, lap, mode_down, load_en;
  logic [MW-1:0] load_min;
  logic [5:0]    load_sec;
  logic [MW-1:0] minutes, lap_minutes;
  logic [5:0]    seconds, lap_seconds;
  logic          lap_valid, wrap, expired;
  logic [1:0]    status;

  always #5 clk = ~clk;

  stopwatch_lap_timer #(
    .TICKS_PER_SEC(TPS),
    .MIN_WIDTH    (MW),
    .MAX_MIN      (MAXM)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .clear      (clear),
    .lap        (lap),
    .mode_down  (mode_down),
    .load_en    (load_en),
    .load_min   (load_min),
    .load_sec   (load_sec),
    .minutes    (minutes),
    .seconds    (seconds),
    .lap_minutes(lap_minutes),
    .lap_seconds(lap_seconds),
    .lap_valid  (lap_valid),
    .wrap       (wrap),
    .expired    (expired),
    .status     (status)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    start = 1'b0; stop = 1'b0; clear = 1'b0; lap = 1'b0;
    mode_down = 1'b0; load_en = 1'b0; load_min = '0; load_sec = '0;
  endtask

  task automatic run_edges(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic       st, sp, cl, lp, md, ld;
    logic [7:0] lmin;
    logic [5:0] lsec;
    int         n;
    int         e_st, e_min, e_sec, e_lapv, e_wrap, e_exp, e_lapsec;
  } vec_t;

  vec_t tbl[40];
  int   nv = 0;

  task automatic add(input int st, input int sp, input int cl, input int lp,
                     input int md, input int ld, input int lmin, input int lsec,
                     input int n, input int e_st, input int e_min, input int e_sec,
                     input int e_lapv, input int e_wrap, input int e_exp,
                     input int e_lapsec);
    tbl[nv].st = (st != 0); tbl[nv].sp = (sp != 0); tbl[nv].cl = (cl != 0);
    tbl[nv].lp = (lp != 0); tbl[nv].md = (md != 0); tbl[nv].ld = (ld != 0);
    tbl[nv].lmin = 8'(lmin); tbl[nv].lsec = 6'(lsec); tbl[nv].n = n;
    tbl[nv].e_st = e_st; tbl[nv].e_min = e_min; tbl[nv].e_sec = e_sec;
    tbl[nv].e_lapv = e_lapv; tbl[nv].e_wrap = e_wrap; tbl[nv].e_exp = e_exp;
    tbl[nv].e_lapsec = e_lapsec;
    nv++;
  endtask

  // ---------------- reference model (total seconds) ----------------
  int m_st, m_t, m_ps, m_lapt;
  bit m_mode, m_lapv, m_wrap, m_exp;

  task automatic model_reset();
    m_st = 0; m_t = 0; m_ps = 0; m_lapt = 0;
    m_mode = 1'b0; m_lapv = 1'b0; m_wrap = 1'b0; m_exp = 1'b0;
  endtask

  function automatic int load_time();
    int lm, ls;
    lm = int'(load_min);
    ls = int'(load_sec);
    if (lm > MAXM) lm = MAXM;
    if (ls > 59) ls = 59;
    return lm * 60 + ls;
  endfunction

  // Advances the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    m_lapv = 1'b0; m_wrap = 1'b0; m_exp = 1'b0;
    if (clear) begin
      m_st = 0; m_t = 0; m_ps = 0; m_lapt = 0;
      return;
    end
    if (m_st == 1 && lap) begin
      m_lapt = m_t;
      m_lapv = 1'b1;
    end
    case (m_st)
      0: begin
        if (load_en) m_t = load_time();
        else if (start && !stop && !(mode_down && m_t == 0)) begin
          m_st = 1; m_mode = mode_down; m_ps = 0;
        end
      end
      2: begin
        if (load_en) m_t = load_time();
        else if (start && !stop) m_st = 1;
      end
      1: begin
        if (stop) m_st = 2;
        else begin
          m_ps++;
          if (m_ps == TPS) begin
            m_ps = 0;
            if (m_mode) begin
              if (m_t <= 1) begin m_t = 0; m_st = 3; m_exp = 1'b1; end
              else m_t--;
            end else begin
              m_t = (m_t + 1) % SPAN;
              if (m_t == 0) m_wrap = 1'b1;
            end
          end
        end
      end
      default: ;
    endcase
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    run_edges(2);

    // Reset state
    chk("reset status",  32'(status),  0);
    chk("reset minutes", 32'(minutes), 0);
    chk("reset seconds", 32'(seconds), 0);
    chk("reset pulses",  32'({lap_valid, wrap, expired}), 0);
    chk("reset lap",     32'({lap_minutes, lap_seconds}), 0);
    rst = 1'b0;
    run_edges(1);

    // Count-up from reset, then async reset mid-count at 3:12
    start = 1'b1;
    run_edges(1);
    start = 1'b0;
    chk("up status after start", 32'(status), 1);
    chk("up sec at start",       32'(seconds), 0);
    run_edges(3);
    chk("up sec before first tick", 32'(seconds), 0);
    run_edges(1);
    chk("up first tick", 32'(seconds), 1);
    run_edges(56);
    chk("up sec after 60", 32'(seconds), 15);
    run_edges(708);
    chk("up min at 3:12", 32'(minutes), 3);
    chk("up sec at 3:12", 32'(seconds), 12);
    #2;
    rst = 1'b1;
    #1;
    chk("async rst minutes", 32'(minutes), 0);
    chk("async rst seconds", 32'(seconds), 0);
    chk("async rst status",  32'(status),  0);
    #1;
    rst = 1'b0;
    run_edges(1);

    // Table: rollover, countdown/expiry, lap and priority, load clamping
    //   st sp cl lp md ld lmin lsec n  | st min sec lapv wrap exp lapsec
    add(0, 0, 0, 0, 0, 1, 99, 58, 1,  0, 99, 58, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0,  0,  0, 1,  1, 99, 58, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0,  0,  0, 3,  1, 99, 58, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0,  0,  0, 1,  1, 99, 59, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0,  0,  0, 3,  1, 99, 59, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0,  0,  0, 1,  1,  0,  0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0,  0,  0, 1,  1,  0,  0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0,  0,  0, 3,  1,  0,  1, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0,  0,  0, 1,  0,  0,  0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1,  0,  2, 1,  0,  0,  2, 0, 0, 0, 0);
    add(1, 0, 0, 0, 1, 0,  0,  0, 1,  1,  0,  2, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0,  0,  0, 4,  1,  0,  1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0,  0,  0, 3,  1,  0,  1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0,  0,  0, 1,  3,  0,  0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0,  0,  0, 1,  3,  0,  0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0,  0,  0, 1,  3,  0,  0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0,  0,  0, 1,  3,  0,  0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0,  0,  0, 1,  0,  0,  0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 1, 0,  0,  0, 1,  0,  0,  0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1,  0,  6, 1,  0,  0,  6, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0,  0,  0, 1,  1,  0,  6, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0,  0,  0, 4,  1,  0,  7, 0, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0,  0,  0, 1,  1,  0,  7, 1, 0, 0, 7);
    add(0, 0, 0, 0, 0, 0,  0,  0, 1,  1,  0,  7, 0, 0, 0, 7);
    add(0, 1, 0, 0, 0, 0,  0,  0, 1,  2,  0,  7, 0, 0, 0, 7);
    add(0, 0, 0, 0, 0, 1,  0, 30, 1,  2,  0, 30, 0, 0, 0, 7);
    add(0, 0, 0, 1, 0, 0,  0,  0, 1,  2,  0, 30, 0, 0, 0, 7);
    add(1, 0, 0, 0, 0, 0,  0,  0, 1,  1,  0, 30, 0, 0, 0, 7);
    add(0, 0, 0, 0, 0, 0,  0,  0, 1,  1,  0, 30, 0, 0, 0, 7);
    add(0, 0, 0, 0, 0, 0,  0,  0, 1,  1,  0, 31, 0, 0, 0, 7);
    add(1, 1, 0, 0, 0, 0,  0,  0, 1,  2,  0, 31, 0, 0, 0, 7);
    add(1, 0, 1, 0, 0, 0,  0,  0, 1,  0,  0,  0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 200, 63, 1, 0, 99, 59, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0,  0,  0, 1,  0,  0,  0, 0, 0, 0, 0);

    for (int i = 0; i < nv; i++) begin
      start = tbl[i].st; stop = tbl[i].sp; clear = tbl[i].cl; lap = tbl[i].lp;
      mode_down = tbl[i].md; load_en = tbl[i].ld;
      load_min = tbl[i].lmin; load_sec = tbl[i].lsec;
      run_edges(1);
      idle_inputs();
      if (tbl[i].n > 1) run_edges(tbl[i].n - 1);
      chk($sformatf("row%0d status", i),  32'(status),  tbl[i].e_st);
      chk($sformatf("row%0d minutes", i), 32'(minutes), tbl[i].e_min);
      chk($sformatf("row%0d seconds", i), 32'(seconds), tbl[i].e_sec);
      chk($sformatf("row%0d pulses", i),  32'({lap_valid, wrap, expired}),
          (tbl[i].e_lapv << 2) | (tbl[i].e_wrap << 1) | tbl[i].e_exp);
      chk($sformatf("row%0d lap_seconds", i), 32'(lap_seconds), tbl[i].e_lapsec);
    end

    // Randomized run against the model
    rst = 1'b1;
    #2;
    rst = 1'b0;
    model_reset();
    run_edges(1);
    for (int c = 0; c < 6000; c++) begin
      int r;
      idle_inputs();
      clear     = ($urandom_range(0, 299) == 0);
      start     = ($urandom_range(0, 9) == 0);
      stop      = ($urandom_range(0, 39) == 0);
      lap       = ($urandom_range(0, 15) == 0);
      mode_down = ($urandom_range(0, 1) == 1);
      if (!start && !stop) load_en = ($urandom_range(0, 29) == 0);
      r = int'($urandom_range(0, 3));
      case (r)
        0:       load_min = 8'd0;
        1:       load_min = 8'(MAXM);
        2:       load_min = 8'($urandom_range(100, 255));
        default: load_min = 8'($urandom_range(0, 98));
      endcase
      load_sec = 6'($urandom_range(0, 63));
      model_edge();
      run_edges(1);
      chk("rnd status",      32'(status),      m_st);
      chk("rnd minutes",     32'(minutes),     m_t / 60);
      chk("rnd seconds",     32'(seconds),     m_t % 60);
      chk("rnd lap_minutes", 32'(lap_minutes), m_lapt / 60);
      chk("rnd lap_seconds", 32'(lap_seconds), m_lapt % 60);
      chk("rnd pulses",      32'({lap_valid, wrap, expired}), 32'({m_lapv, m_wrap, m_exp}));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
